// File: rtl/demux1x4_stream_if.sv
// demux1x4_stream_if: producer-side input stream plus four consumer channels.
// master = the producer/consumer environment, slave = the demultiplexer.
interface demux1x4_stream_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0]   in_data;
   logic [1:0]         in_sel;
   logic               in_valid;
   logic               in_ready;
   logic [4*WIDTH-1:0] out_data;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
   logic [3:0]         ch_full;

   modport master (
      output in_data, in_sel, in_valid, out_ready,
      input  in_ready, out_data, out_valid, ch_full
   );

   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
      output in_ready, out_data, out_valid, ch_full
   );
endinterface

// File: rtl/demux1x4_stream.sv
// demux1x4_stream: steers each input word to one of four 2-entry channel FIFOs.
// Destination is in_sel by default; define DEMUX_RR_EN to use an internal
// round-robin pointer that advances only on accepted pushes.
module demux1x4_stream #(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   demux1x4_stream_if.slave  bus
);
   localparam int unsigned NCH = 4;
   localparam int unsigned DEPTH = 2;

   logic [1:0]       dest;
   logic             push;
   logic [NCH-1:0]   wr_c;
   logic [NCH-1:0]   pop_c;

   logic [1:0]       count_q [NCH];
   logic [1:0]       count_d [NCH];
   logic [NCH-1:0]   head_q, head_d;
   logic [NCH-1:0]   tail_q, tail_d;
   logic [WIDTH-1:0] mem_q   [NCH][DEPTH];
   logic [WIDTH-1:0] data_q  [NCH];
   logic [WIDTH-1:0] data_d  [NCH];
   logic [NCH-1:0]   valid_q, valid_d;
   logic [NCH-1:0]   full_q, full_d;

`ifdef DEMUX_RR_EN
   logic [1:0] rr_q;
   logic [1:0] rr_d;
   logic [1:0] unused_sel;

   assign unused_sel = bus.in_sel;
   assign dest       = rr_q;

   // Round-robin pointer advances only when a word is actually accepted.
   always_comb begin
      rr_d = rr_q;
      if (push) rr_d = rr_q + 2'd1;
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_q <= 2'd0;
      else        rr_q <= rr_d;
   end
`else
   assign dest = bus.in_sel;
`endif

   // Accept only when the destination has room; a same-cycle pop does not count.
   assign bus.in_ready = (count_q[dest] != 2'd2);
   assign push         = bus.in_valid && bus.in_ready;
   assign pop_c        = valid_q & bus.out_ready;

   // One-hot write enable for the destination channel.
   always_comb begin
      wr_c = '0;
      if (push) wr_c[dest] = 1'b1;
   end

   // Next count, pointers and visible head word per channel.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = '0;
      full_d  = '0;
      for (int k = 0; k < NCH; k++) begin
         count_d[k] = count_q[k];
         data_d[k]  = data_q[k];
         case ({wr_c[k], pop_c[k]})
            2'b10:   count_d[k] = count_q[k] + 2'd1;
            2'b01:   count_d[k] = count_q[k] - 2'd1;
            default: count_d[k] = count_q[k];
         endcase
         if (wr_c[k])  tail_d[k] = ~tail_q[k];
         if (pop_c[k]) head_d[k] = ~head_q[k];
         // New head is the incoming word when the channel was empty or is
         // replacing its only word; otherwise the second stored word.
         if (wr_c[k] && ((count_q[k] == 2'd0) || ((count_q[k] == 2'd1) && pop_c[k])))
            data_d[k] = bus.in_data;
         else if (pop_c[k] && (count_q[k] == 2'd2))
            data_d[k] = mem_q[k][~head_q[k]];
         valid_d[k] = (count_d[k] != 2'd0);
         full_d[k]  = (count_d[k] == 2'd2);
      end
   end

   // Channel state, storage and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
         full_q  <= '0;
         for (int k = 0; k < NCH; k++) begin
            count_q[k] <= 2'd0;
            data_q[k]  <= '0;
            for (int e = 0; e < DEPTH; e++) mem_q[k][e] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
         full_q  <= full_d;
         for (int k = 0; k < NCH; k++) begin
            count_q[k] <= count_d[k];
            data_q[k]  <= data_d[k];
            if (wr_c[k]) mem_q[k][tail_q[k]] <= bus.in_data;
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.ch_full   = full_q;

   for (genvar k = 0; k < NCH; k++) begin : g_out
      assign bus.out_data[k*WIDTH +: WIDTH] = data_q[k];
   end
endmodule

// File: tb/tb_demux1x4_stream.sv
// tb_demux1x4_stream: directed stimulus with a queue-based channel model
// checked every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_demux1x4_stream;
   localparam int unsigned W = 8;
`ifdef DEMUX_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   demux1x4_stream_if #(.WIDTH(W)) bus();

   demux1x4_stream #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: one queue per channel plus the last visible head word.
   logic [W-1:0] mq [4][$];
   logic [W-1:0] last_head [4];
   int           m_rr;
   int           m_d;
   bit           m_push;
   bit           m_pop [4];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            last_head[k] = '0;
         end
         m_rr = 0;
      end else begin
         m_d    = RR ? m_rr : int'(bus.in_sel);
         m_push = bus.in_valid && (mq[m_d].size() < 2);
         for (int k = 0; k < 4; k++)
            m_pop[k] = (mq[k].size() != 0) && bus.out_ready[k];
         for (int k = 0; k < 4; k++)
            if (m_pop[k]) void'(mq[k].pop_front());
         if (m_push) begin
            mq[m_d].push_back(bus.in_data);
            m_rr = (m_rr + 1) % 4;
         end
         for (int k = 0; k < 4; k++)
            if (mq[k].size() != 0) last_head[k] = mq[k][0];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   logic [3:0]     e_valid, e_full;
   logic [4*W-1:0] e_data;
   logic           e_ready;
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         e_valid[k] = (mq[k].size() != 0);
         e_full[k]  = (mq[k].size() == 2);
         e_data[k*W +: W] = last_head[k];
      end
      e_ready = mq[RR ? m_rr : int'(bus.in_sel)].size() < 2;
      chk("model_out_valid", 64'(bus.out_valid), 64'(e_valid));
      chk("model_ch_full",   64'(bus.ch_full),   64'(e_full));
      chk("model_out_data",  64'(bus.out_data),  64'(e_data));
      chk("model_in_ready",  64'(bus.in_ready),  64'(e_ready));
   end

   function automatic logic [W-1:0] sl(input int k);
      logic [4*W-1:0] v;
      v = bus.out_data;
      return v[k*W +: W];
   endfunction

   // Drive one cycle of inputs, then land 1 ns after the next rising edge.
   task automatic cyc(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
      bus.in_valid  = v;
      bus.in_sel    = s;
      bus.in_data   = d;
      bus.out_ready = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'd2;
      bus.in_data   = 8'hFF;
      bus.out_ready = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
      chk("rst_ch_full",   64'(bus.ch_full),   64'h0);
      chk("rst_out_data",  64'(bus.out_data),  64'h0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'h1);
      rst_n = 1'b1;
      cyc(1'b0, 2'd0, 8'h00, 4'b0000);
      chk("rst_no_push", 64'(bus.out_valid), 64'h0);

`ifndef DEMUX_RR_EN
      // Single push / pop, head holds after drain
      cyc(1'b1, 2'd2, 8'hA5, 4'b0000);
      chk("a5_valid", 64'(bus.out_valid), 64'b0100);
      chk("a5_data",  64'(sl(2)), 64'hA5);
      cyc(1'b0, 2'd0, 8'h00, 4'b0100);
      chk("a5_popped", 64'(bus.out_valid), 64'h0);
      chk("a5_hold",   64'(sl(2)), 64'hA5);

      // Fill ch1 and check backpressure
      cyc(1'b1, 2'd1, 8'h11, 4'b0000);
      cyc(1'b1, 2'd1, 8'h22, 4'b0000);
      chk("fill_full", 64'(bus.ch_full), 64'b0010);
      chk("fill_head", 64'(sl(1)), 64'h11);
      bus.in_valid = 1'b0;
      bus.in_sel   = 2'd1;
      #1 chk("bp_ready_sel1", 64'(bus.in_ready), 64'h0);
      bus.in_sel   = 2'd0;
      #1 chk("bp_ready_sel0", 64'(bus.in_ready), 64'h1);
      cyc(1'b1, 2'd1, 8'h33, 4'b0000);
      chk("bp_blocked_head", 64'(sl(1)), 64'h11);
      cyc(1'b0, 2'd0, 8'h00, 4'b0010);
      chk("pop1_head",  64'(sl(1)), 64'h22);
      chk("pop1_valid", 64'(bus.out_valid), 64'b0010);
      chk("pop1_full",  64'(bus.ch_full), 64'h0);
      cyc(1'b0, 2'd0, 8'h00, 4'b0010);
      chk("pop2_valid", 64'(bus.out_valid), 64'h0);

      // Count 1 with simultaneous push and pop
      cyc(1'b1, 2'd3, 8'h33, 4'b0000);
      chk("c3_head", 64'(sl(3)), 64'h33);
      cyc(1'b1, 2'd3, 8'h44, 4'b1000);
      chk("pp_head",  64'(sl(3)), 64'h44);
      chk("pp_valid", 64'(bus.out_valid), 64'b1000);
      chk("pp_full",  64'(bus.ch_full), 64'h0);
      cyc(1'b0, 2'd0, 8'h00, 4'b1000);
      chk("pp_drain", 64'(bus.out_valid), 64'h0);

      // Full channel popped while a push is offered
      cyc(1'b1, 2'd0, 8'h55, 4'b0000);
      cyc(1'b1, 2'd0, 8'h66, 4'b0000);
      chk("c0_full", 64'(bus.ch_full), 64'b0001);
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'd0;
      bus.in_data   = 8'h77;
      bus.out_ready = 4'b0001;
      #1 chk("fp_ready", 64'(bus.in_ready), 64'h0);
      @(posedge clk);
      #1;
      chk("fp_head",  64'(sl(0)), 64'h66);
      chk("fp_full",  64'(bus.ch_full), 64'h0);
      chk("fp_ready_after", 64'(bus.in_ready), 64'h1);
      cyc(1'b1, 2'd0, 8'h77, 4'b0000);
      chk("fp_accept_full", 64'(bus.ch_full), 64'b0001);
      chk("fp_accept_head", 64'(sl(0)), 64'h66);
      cyc(1'b0, 2'd0, 8'h00, 4'b0001);
      chk("fp_next", 64'(sl(0)), 64'h77);
      cyc(1'b0, 2'd0, 8'h00, 4'b0001);
      chk("fp_drain", 64'(bus.out_valid), 64'h0);
`else
      // Round-robin order regardless of in_sel
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 2'd3, 8'(i + 1), 4'b1111);
         chk("rr_valid", 64'(bus.out_valid), 64'(4'b0001 << (i % 4)));
         chk("rr_data",  64'(sl(i % 4)), 64'(i + 1));
      end
      cyc(1'b0, 2'd0, 8'h00, 4'b1111);
      chk("rr_drain", 64'(bus.out_valid), 64'h0);
      // Fill all channels starting at ch2
      for (int i = 0; i < 8; i++) cyc(1'b1, 2'd3, 8'(8'h10 + i), 4'b0000);
      chk("rr_all_full", 64'(bus.ch_full), 64'hF);
      chk("rr_c2_head",  64'(sl(2)), 64'h10);
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h18;
      bus.out_ready = 4'b0000;
      #1 chk("rr_stall_ready", 64'(bus.in_ready), 64'h0);
      @(posedge clk);
      #1;
      chk("rr_stall_hold", 64'(bus.in_ready), 64'h0);
      cyc(1'b1, 2'd3, 8'h18, 4'b0100);
      chk("rr_stall_pop", 64'(sl(2)), 64'h14);
      cyc(1'b1, 2'd3, 8'h18, 4'b0000);
      chk("rr_stall_accept", 64'(bus.ch_full), 64'hF);
      cyc(1'b0, 2'd0, 8'h00, 4'b0100);
      chk("rr_stall_word", 64'(sl(2)), 64'h18);
      cyc(1'b0, 2'd0, 8'h00, 4'b1111);
      cyc(1'b0, 2'd0, 8'h00, 4'b1111);
      chk("rr_drain2", 64'(bus.out_valid), 64'h0);
`endif

      // Mixed traffic burst, checked by the model
      for (int i = 0; i < 24; i++)
         cyc((i % 5) != 4, 2'((i * 3) % 4), 8'(i * 7 + 1), 4'(i * 5 + 3));
      cyc(1'b0, 2'd0, 8'h00, 4'b1111);
      cyc(1'b0, 2'd0, 8'h00, 4'b1111);
      chk("burst_drain", 64'(bus.out_valid), 64'h0);

      // Mid-stream reset discards buffered words immediately
      for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i), 8'(8'h80 + i), 4'b0000);
      chk("mr_loaded", 64'(bus.out_valid), 64'hF);
      bus.in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mr_valid", 64'(bus.out_valid), 64'h0);
      chk("mr_full",  64'(bus.ch_full),   64'h0);
      chk("mr_data",  64'(bus.out_data),  64'h0);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 2'd0, 8'h00, 4'b1111);
         chk("mr_gone", 64'(bus.out_valid), 64'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
